// File: rtl/wb_struct_pkg.sv
// Shared Wishbone B3 definitions: cycle-type / burst-type codes and the
// responder FSM states used by the slave memory and the burst master BFM.
package wb_struct_pkg;

   localparam logic [2:0] WB_CTI_CLASSIC = 3'b000;
   localparam logic [2:0] WB_CTI_CONST   = 3'b001;
   localparam logic [2:0] WB_CTI_INCR    = 3'b010;
   localparam logic [2:0] WB_CTI_EOB     = 3'b111;

   localparam logic [1:0] WB_BTE_LINEAR  = 2'b00;
   localparam logic [1:0] WB_BTE_WRAP4   = 2'b01;
   localparam logic [1:0] WB_BTE_WRAP8   = 2'b10;
   localparam logic [1:0] WB_BTE_WRAP16  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_XFER = 2'd2,
      ST_DONE = 2'd3
   } wb_slv_state_e;

   // A beat carrying one of these codes announces another beat behind it.
   function automatic logic cti_continues(input logic [2:0] cti);
      return (cti == WB_CTI_INCR) || (cti == WB_CTI_CONST);
   endfunction

endpackage

// File: rtl/wb_slave_mem_addr_gen.sv
// Combinational next-beat byte address for Wishbone bursts (linear or
// wrap-4/8/16); reusable by any burst master or slave.
module wb_burst_addr_gen
   import wb_struct_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 32
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   input  logic [2:0]            i_cti,
   input  logic [1:0]            i_bte,
   output logic [ADDR_WIDTH-1:0] o_addr
);

   localparam int unsigned WW = ADDR_WIDTH - 2;

   logic [WW-1:0] w_word;
   logic [WW-1:0] w_inc;
   logic [WW-1:0] w_mask;

   always_comb begin
      w_word = i_addr[ADDR_WIDTH-1:2];
      w_inc  = w_word + WW'(1);
      case (i_bte)
         WB_BTE_WRAP4:  w_mask = WW'(3);
         WB_BTE_WRAP8:  w_mask = WW'(7);
         WB_BTE_WRAP16: w_mask = WW'(15);
         default:       w_mask = '1;
      endcase
      o_addr = i_addr;
      // Wrapping bursts only advance the low word bits; the block base holds.
      if (i_cti == WB_CTI_INCR)
         o_addr = {(w_word & ~w_mask) | (w_inc & w_mask), i_addr[1:0]};
   end

endmodule

// File: rtl/wb_slave_mem.sv
// Wishbone B3 responder memory with byte-lane writes, classic and CTI/BTE
// bursts, programmable first-beat wait states and error injection.
module wb_slave_mem
   import wb_struct_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH = 32,
   parameter int unsigned           DATA_WIDTH = 32,
   parameter int unsigned           SEL_WIDTH  = 4,
   parameter int unsigned           MEM_AW     = 10,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_i,
   input  logic [ADDR_WIDTH-1:0] wb_adr_i,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   input  logic [SEL_WIDTH-1:0]  wb_sel_i,
   input  logic                  wb_we_i,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic [2:0]            wb_cti_i,
   input  logic [1:0]            wb_bte_i,
   output logic                  wb_ack_o,
   output logic                  wb_err_o,
   input  logic [3:0]            wait_cfg_i,
   input  logic                  err_inj_en_i,
   input  logic [ADDR_WIDTH-1:0] err_inj_adr_i,
   output logic [15:0]           beat_cnt_o
);

   localparam int unsigned DEPTH = 1 << MEM_AW;

   wb_slv_state_e         r_state;
   wb_slv_state_e         w_state_nxt;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [1:0]            r_bte;
   logic [3:0]            r_wait;
   logic                  r_ack;
   logic                  r_err;
   logic [DATA_WIDTH-1:0] r_dat;
   logic [15:0]           r_beat_cnt;
   logic [DATA_WIDTH-1:0] r_mem [DEPTH];

   logic                  w_req;
   logic                  w_ack;
   logic                  w_err;
   logic                  w_issue;
   logic                  w_issue_bad;
   logic [ADDR_WIDTH-1:0] w_issue_addr;
   logic [ADDR_WIDTH-1:0] w_next_addr;
   logic [MEM_AW-1:0]     w_issue_word;
   logic [MEM_AW-1:0]     w_cur_word;
   logic                  w_unused;

   wb_burst_addr_gen #(
      .ADDR_WIDTH(ADDR_WIDTH)
   ) u_addr_gen (
      .i_addr (r_addr),
      .i_cti  (wb_cti_i),
      .i_bte  (r_bte),
      .o_addr (w_next_addr)
   );

   assign w_req    = wb_cyc_i & wb_stb_i;
   assign w_ack    = r_ack & w_req;
   assign w_err    = r_err & w_req;
   assign w_unused = ^err_inj_adr_i[1:0];

   // The ack flag is registered one beat ahead: the edge that completes a
   // beat also issues the next one, so a held strobe gets one beat per cycle.
   always_comb begin
      w_issue_addr = r_addr;
      if (r_state == ST_IDLE)
         w_issue_addr = wb_adr_i;
      else if (r_state == ST_XFER)
         w_issue_addr = w_next_addr;
      w_issue_word = w_issue_addr[MEM_AW+1:2];
      w_cur_word   = r_addr[MEM_AW+1:2];
      w_issue_bad  = (w_issue_addr[ADDR_WIDTH-1:MEM_AW+2] != BASE_ADDR[ADDR_WIDTH-1:MEM_AW+2]) ||
                     (err_inj_en_i && (w_issue_addr[ADDR_WIDTH-1:2] == err_inj_adr_i[ADDR_WIDTH-1:2]));
   end

   always_comb begin
      w_state_nxt = r_state;
      w_issue     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_req) begin
               if (wait_cfg_i == 4'd0) begin
                  w_state_nxt = ST_XFER;
                  w_issue     = 1'b1;
               end else begin
                  w_state_nxt = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (!wb_cyc_i) begin
               w_state_nxt = ST_IDLE;
            end else if (wb_stb_i && (r_wait <= 4'd1)) begin
               w_state_nxt = ST_XFER;
               w_issue     = 1'b1;
            end
         end
         ST_XFER: begin
            if (!wb_cyc_i)
               w_state_nxt = ST_IDLE;
            else if (w_err)
               w_state_nxt = ST_DONE;
            else if (w_ack) begin
               if (cti_continues(wb_cti_i))
                  w_issue = 1'b1;
               else
                  w_state_nxt = ST_DONE;
            end
         end
         default: begin
            if (!wb_cyc_i || !wb_stb_i)
               w_state_nxt = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         r_state    <= ST_IDLE;
         r_addr     <= '0;
         r_bte      <= WB_BTE_LINEAR;
         r_wait     <= '0;
         r_ack      <= 1'b0;
         r_err      <= 1'b0;
         r_dat      <= '0;
         r_beat_cnt <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_IDLE) && w_req) begin
            r_addr <= wb_adr_i;
            r_bte  <= wb_bte_i;
            r_wait <= wait_cfg_i;
         end else if ((r_state == ST_WAIT) && w_req && (r_wait > 4'd1)) begin
            r_wait <= r_wait - 4'd1;
         end
         if (w_issue) begin
            r_addr <= w_issue_addr;
            r_ack  <= ~w_issue_bad;
            r_err  <= w_issue_bad;
            r_dat  <= r_mem[w_issue_word];
         end else if (w_state_nxt != ST_XFER) begin
            r_ack <= 1'b0;
            r_err <= 1'b0;
         end
         if (w_ack)
            r_beat_cnt <= r_beat_cnt + 16'd1;
      end
   end

   // Storage is not reset; a beat caught by reset is dropped, not written.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_i && w_ack && wb_we_i) begin
         for (int unsigned i = 0; i < SEL_WIDTH; i++) begin
            if (wb_sel_i[i])
               r_mem[w_cur_word][8*i +: 8] <= wb_dat_i[8*i +: 8];
         end
      end
   end

   assign wb_ack_o   = w_ack;
   assign wb_err_o   = w_err;
   assign wb_dat_o   = r_dat;
   assign beat_cnt_o = r_beat_cnt;

endmodule

// File: tb/tb_wb_slave_mem.sv
// Self-checking bench for wb_slave_mem: randomized classic and burst traffic
// checked against a word-array reference model and an expected beat count.
module tb_wb_slave_mem;
   import wb_struct_pkg::*;

   logic        wb_clk_i = 1'b0;
   logic        wb_rst_i = 1'b1;
   logic [31:0] wb_adr_i = '0;
   logic [31:0] wb_dat_i = '0;
   logic [31:0] wb_dat_o;
   logic [3:0]  wb_sel_i = '0;
   logic        wb_we_i  = 1'b0;
   logic        wb_cyc_i = 1'b0;
   logic        wb_stb_i = 1'b0;
   logic [2:0]  wb_cti_i = '0;
   logic [1:0]  wb_bte_i = '0;
   logic        wb_ack_o;
   logic        wb_err_o;
   logic [3:0]  wait_cfg_i = '0;
   logic        err_inj_en_i = 1'b0;
   logic [31:0] err_inj_adr_i = '0;
   logic [15:0] beat_cnt_o;

   int unsigned n_pass = 0;
   int unsigned n_total = 0;
   int unsigned exp_cnt = 0;
   logic [31:0] model_mem [int unsigned];
   logic [31:0] wdata [16];
   logic [31:0] rdat_q [$];
   logic [31:0] adr_q [$];

   always #5 wb_clk_i = ~wb_clk_i;

   wb_slave_mem #(
      .ADDR_WIDTH(32), .DATA_WIDTH(32), .SEL_WIDTH(4), .MEM_AW(10), .BASE_ADDR(32'h0)
   ) dut (
      .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i),
      .wb_dat_o(wb_dat_o), .wb_sel_i(wb_sel_i), .wb_we_i(wb_we_i), .wb_cyc_i(wb_cyc_i),
      .wb_stb_i(wb_stb_i), .wb_cti_i(wb_cti_i), .wb_bte_i(wb_bte_i), .wb_ack_o(wb_ack_o),
      .wb_err_o(wb_err_o), .wait_cfg_i(wait_cfg_i), .err_inj_en_i(err_inj_en_i),
      .err_inj_adr_i(err_inj_adr_i), .beat_cnt_o(beat_cnt_o)
   );

   task automatic tick();
      @(posedge wb_clk_i);
      #1;
   endtask

   // Burst order from the wrap rule: stay inside the len-word aligned block.
   function automatic logic [31:0] next_adr(input logic [31:0] a, input logic [1:0] bte);
      int unsigned w, len, base;
      logic [31:0] r;
      w   = a >> 2;
      len = (bte == 2'd0) ? 0 : (2 << bte);
      if (len == 0) w = w + 1;
      else begin
         base = w - (w % len);
         w    = base + ((w - base + 1) % len);
      end
      r = w << 2;
      return r | {30'b0, a[1:0]};
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] sel);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (sel[i]) r[8*i +: 8] = nw[8*i +: 8];
      return r;
   endfunction

   // Master BFM: registered-feedback burst, one beat per edge while stb held.
   task automatic bus_xfer(input logic we, input logic [31:0] adr0, input logic [3:0] sel,
                           input int n, input logic [2:0] cti_mode, input logic [1:0] bte,
                           input int unsigned pause_pct, input int rst_beat,
                           output int unsigned nack, output logic got_err, output logic tmo,
                           output int unsigned lat, output logic leak);
      logic [31:0] adr;
      int unsigned guard;
      adr = adr0; nack = 0; got_err = 0; tmo = 0; lat = 0; leak = 0;
      rdat_q.delete(); adr_q.delete();
      wb_we_i = we; wb_sel_i = sel; wb_bte_i = bte; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      for (int k = 0; k < n; k++) begin
         wb_adr_i = adr;
         wb_dat_i = wdata[k];
         wb_cti_i = (n == 1) ? WB_CTI_CLASSIC : ((k == n - 1) ? WB_CTI_EOB : cti_mode);
         if (k > 0 && $urandom_range(99) < pause_pct) begin
            wb_stb_i = 1'b0;
            #1;
            if (wb_ack_o || wb_err_o) leak = 1'b1;
            tick();
            if (wb_ack_o || wb_err_o) leak = 1'b1;
            wb_stb_i = 1'b1;
            #1;
         end
         guard = 0;
         while (!(wb_ack_o || wb_err_o) && guard < 64) begin
            tick();
            guard++;
         end
         if (guard >= 64) begin
            tmo = 1'b1;
            break;
         end
         if (k == 0) lat = guard;
         if (k == rst_beat) begin
            wb_rst_i = 1'b1;
            tick();
            return;
         end
         rdat_q.push_back(wb_dat_o);
         adr_q.push_back(adr);
         if (wb_err_o) begin
            got_err = 1'b1;
            tick();
            break;
         end
         tick();
         nack++;
         exp_cnt++;
         if (we) model_mem[adr >> 2] = merge(model_mem[adr >> 2], wdata[k], sel);
         if (cti_mode == WB_CTI_INCR) adr = next_adr(adr, bte);
      end
      if (wb_ack_o || wb_err_o) leak = 1'b1;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = '0;
      tick();
   endtask

   task automatic test_reset();
      wb_rst_i = 1'b1;
      repeat (3) tick();
      n_total++;
      if ({wb_ack_o, wb_err_o, wb_dat_o, beat_cnt_o} !== 50'd0)
         $display("FAIL reset_outputs: ack=%b err=%b dat=%h cnt=%0d, required all zero", wb_ack_o, wb_err_o, wb_dat_o, beat_cnt_o);
      else n_pass++;
      wb_rst_i = 1'b0;
      exp_cnt = 0;
      tick();
   endtask

   task automatic test_preload();
      int unsigned na, lat; logic ge, to, lk;
      for (int w = 0; w < 64; w++) begin
         wdata[0] = $urandom;
         model_mem[w] = 32'h0;
         bus_xfer(1'b1, w << 2, 4'hF, 1, WB_CTI_CLASSIC, 2'd0, 0, -1, na, ge, to, lat, lk);
      end
      n_total++;
      if (beat_cnt_o !== exp_cnt[15:0]) $display("FAIL preload_cnt: got %0d required %0d", beat_cnt_o, exp_cnt);
      else n_pass++;
   endtask

   task automatic test_classic();
      int unsigned na, lat; logic ge, to, lk;
      wdata[0] = 32'hA5A5_1234;
      bus_xfer(1'b1, 32'h40, 4'hF, 1, WB_CTI_CLASSIC, 2'd0, 0, -1, na, ge, to, lat, lk);
      bus_xfer(1'b0, 32'h40, 4'hF, 1, WB_CTI_CLASSIC, 2'd0, 0, -1, na, ge, to, lat, lk);
      n_total++;
      if (to || lat != 1) $display("FAIL classic_latency: got %0d (timeout=%b) required 1", lat, to);
      else n_pass++;
      n_total++;
      if (to || rdat_q[0] !== 32'hA5A5_1234) $display("FAIL classic_read: got %h required a5a51234", to ? 32'hx : rdat_q[0]);
      else n_pass++;
      n_total++;
      if (beat_cnt_o !== exp_cnt[15:0]) $display("FAIL classic_cnt: got %0d required %0d", beat_cnt_o, exp_cnt);
      else n_pass++;
      wdata[0] = 32'hFFFF_FFFF;
      bus_xfer(1'b1, 32'h10, 4'hF, 1, WB_CTI_CLASSIC, 2'd0, 0, -1, na, ge, to, lat, lk);
      wdata[0] = 32'h1122_3344;
      bus_xfer(1'b1, 32'h10, 4'b0101, 1, WB_CTI_CLASSIC, 2'd0, 0, -1, na, ge, to, lat, lk);
      bus_xfer(1'b0, 32'h10, 4'hF, 1, WB_CTI_CLASSIC, 2'd0, 0, -1, na, ge, to, lat, lk);
      n_total++;
      if (to || rdat_q[0] !== 32'hFF22_FF44) $display("FAIL byte_write: got %h required ff22ff44", to ? 32'hx : rdat_q[0]);
      else n_pass++;
   endtask

   task automatic test_wait_states();
      int unsigned edges;
      wait_cfg_i = 4'd3;
      wb_adr_i = 32'h40; wb_we_i = 1'b0; wb_sel_i = 4'hF; wb_cti_i = WB_CTI_CLASSIC;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      tick();
      wb_stb_i = 1'b0;
      tick(); tick();
      n_total++;
      if (wb_ack_o !== 1'b0) $display("FAIL wait_paused_ack: got %b required 0", wb_ack_o);
      else n_pass++;
      wb_stb_i = 1'b1;
      #1;
      edges = 1;
      while (!wb_ack_o && edges < 40) begin tick(); edges++; end
      n_total++;
      if (edges != 4) $display("FAIL wait3_latency: got %0d strobed edges required 4", edges);
      else n_pass++;
      n_total++;
      if (wb_dat_o !== model_mem[32'h10]) $display("FAIL wait3_data: got %h required %h", wb_dat_o, model_mem[32'h10]);
      else n_pass++;
      tick(); exp_cnt++;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();
      wait_cfg_i = 4'd2;
      wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
      tick();
      wait_cfg_i = 4'd7;
      edges = 1;
      while (!wb_ack_o && edges < 40) begin tick(); edges++; end
      n_total++;
      if (edges != 3) $display("FAIL wait_cfg_midcycle: got %0d required 3", edges);
      else n_pass++;
      tick(); exp_cnt++;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
      tick();
      wait_cfg_i = 4'd0;
   endtask

   task automatic test_random_classic();
      int unsigned na, lat, w, wt; logic ge, to, lk, we; logic [3:0] sel;
      for (int it = 0; it < 24; it++) begin
         w = $urandom_range(63); we = 1'($urandom_range(1)); sel = 4'($urandom);
         wt = $urandom_range(5); wait_cfg_i = 4'(wt); wdata[0] = $urandom;
         bus_xfer(we, w << 2, sel, 1, WB_CTI_CLASSIC, 2'd0, 0, -1, na, ge, to, lat, lk);
         n_total++;
         if (to || lat != wt + 1 || na != 1) $display("FAIL rand_classic_lat it%0d: got %0d acks=%0d required %0d", it, lat, na, wt + 1);
         else n_pass++;
         if (!we) begin
            n_total++;
            if (to || rdat_q[0] !== model_mem[w]) $display("FAIL rand_classic_rd w%0d: got %h required %h", w, to ? 32'hx : rdat_q[0], model_mem[w]);
            else n_pass++;
         end
      end
      wait_cfg_i = 4'd0;
   endtask

   task automatic test_bursts();
      int unsigned na, lat, n, s; logic ge, to, lk; logic [1:0] bte; logic [31:0] e;
      for (int i = 0; i < 16; i++) wdata[i] = 32'hD000_0000 + 32'(i);
      bus_xfer(1'b1, 32'h0, 4'hF, 16, WB_CTI_INCR, WB_BTE_LINEAR, 0, -1, na, ge, to, lat, lk);
      bus_xfer(1'b0, 32'h18, 4'hF, 8, WB_CTI_INCR, WB_BTE_WRAP8, 0, -1, na, ge, to, lat, lk);
      n_total++;
      if (to || na != 8 || lk) $display("FAIL wrap8_acks: got %0d acks leak=%b required 8 leak=0", na, lk);
      else n_pass++;
      for (int k = 0; k < int'(rdat_q.size()); k++) begin
         e = 32'hD000_0000 + 32'((6 + k) % 8);
         n_total++;
         if (rdat_q[k] !== e) $display("FAIL wrap8_beat%0d: got %h required %h", k, rdat_q[k], e);
         else n_pass++;
      end
      bus_xfer(1'b0, 32'h08, 4'hF, 4, WB_CTI_INCR, WB_BTE_WRAP4, 30, -1, na, ge, to, lat, lk);
      for (int k = 0; k < 4; k++) begin
         e = 32'hD000_0000 + 32'((2 + k) % 4);
         n_total++;
         if (to || lk || rdat_q[k] !== e) $display("FAIL wrap4_beat%0d: got %h leak=%b required %h", k, to ? 32'hx : rdat_q[k], lk, e);
         else n_pass++;
      end
      bus_xfer(1'b0, 32'h14, 4'hF, 3, WB_CTI_CONST, WB_BTE_LINEAR, 0, -1, na, ge, to, lat, lk);
      n_total++;
      if (to || na != 3 || rdat_q[2] !== 32'hD000_0005) $display("FAIL const_burst: acks=%0d last=%h required 3 and d0000005", na, to ? 32'hx : rdat_q[2]);
      else n_pass++;
      for (int it = 0; it < 6; it++) begin
         n = $urandom_range(2, 8); bte = 2'($urandom_range(3));
         s = (bte == WB_BTE_LINEAR) ? $urandom_range(64 - n) : $urandom_range(63);
         for (int i = 0; i < 16; i++) wdata[i] = $urandom;
         bus_xfer(1'b1, s << 2, 4'($urandom), int'(n), WB_CTI_INCR, bte, 30, -1, na, ge, to, lat, lk);
         bus_xfer(1'b0, s << 2, 4'hF, int'(n), WB_CTI_INCR, bte, 30, -1, na, ge, to, lat, lk);
         n_total++;
         if (to || lk || na != n) $display("FAIL rand_burst%0d_acks: got %0d leak=%b required %0d", it, na, lk, n);
         else n_pass++;
         for (int k = 0; k < int'(rdat_q.size()); k++) begin
            n_total++;
            if (rdat_q[k] !== model_mem[adr_q[k] >> 2]) $display("FAIL rand_burst%0d_beat%0d: got %h required %h", it, k, rdat_q[k], model_mem[adr_q[k] >> 2]);
            else n_pass++;
         end
      end
   endtask

   task automatic test_error();
      int unsigned na, lat; logic ge, to, lk;
      err_inj_en_i = 1'b1; err_inj_adr_i = 32'h80;
      for (int i = 0; i < 4; i++) wdata[i] = 32'hE000_0000 + 32'(i);
      bus_xfer(1'b1, 32'h78, 4'hF, 4, WB_CTI_INCR, WB_BTE_LINEAR, 0, -1, na, ge, to, lat, lk);
      n_total++;
      if (to || na != 2 || !ge || rdat_q.size() != 3 || lk) $display("FAIL err_inject: acks=%0d err=%b beats=%0d leak=%b required 2,1,3,0", na, ge, rdat_q.size(), lk);
      else n_pass++;
      err_inj_en_i = 1'b0;
      for (int w = 30; w < 34; w++) begin
         bus_xfer(1'b0, w << 2, 4'hF, 1, WB_CTI_CLASSIC, 2'd0, 0, -1, na, ge, to, lat, lk);
         n_total++;
         if (to || rdat_q[0] !== model_mem[w]) $display("FAIL err_readback w%0d: got %h required %h", w, to ? 32'hx : rdat_q[0], model_mem[w]);
         else n_pass++;
      end
      bus_xfer(1'b0, 32'h0000_1000, 4'hF, 1, WB_CTI_CLASSIC, 2'd0, 0, -1, na, ge, to, lat, lk);
      n_total++;
      if (to || !ge || na != 0) $display("FAIL out_of_window: err=%b acks=%0d required err=1 acks=0", ge, na);
      else n_pass++;
      n_total++;
      if (beat_cnt_o !== exp_cnt[15:0]) $display("FAIL err_cnt: got %0d required %0d", beat_cnt_o, exp_cnt);
      else n_pass++;
   endtask

   task automatic test_reset_mid_burst();
      int unsigned na, lat; logic ge, to, lk;
      for (int i = 0; i < 4; i++) wdata[i] = 32'hC0DE_0000 + 32'(i);
      bus_xfer(1'b1, 32'hC0, 4'hF, 4, WB_CTI_INCR, WB_BTE_LINEAR, 0, 2, na, ge, to, lat, lk);
      n_total++;
      if (to || {wb_ack_o, wb_err_o, beat_cnt_o, wb_dat_o} !== 50'd0)
         $display("FAIL reset_midburst: ack=%b err=%b cnt=%0d dat=%h timeout=%b required all zero", wb_ack_o, wb_err_o, beat_cnt_o, wb_dat_o, to);
      else n_pass++;
      exp_cnt = 0;
      wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
      tick();
      wb_rst_i = 1'b0;
      tick();
      for (int w = 48; w < 52; w++) begin
         bus_xfer(1'b0, w << 2, 4'hF, 1, WB_CTI_CLASSIC, 2'd0, 0, -1, na, ge, to, lat, lk);
         n_total++;
         if (to || rdat_q[0] !== model_mem[w]) $display("FAIL reset_retained w%0d: got %h required %h", w, to ? 32'hx : rdat_q[0], model_mem[w]);
         else n_pass++;
      end
      n_total++;
      if (beat_cnt_o !== exp_cnt[15:0]) $display("FAIL reset_cnt_after: got %0d required %0d", beat_cnt_o, exp_cnt);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_preload();
      test_classic();
      test_wait_states();
      test_random_classic();
      test_bursts();
      test_error();
      test_reset_mid_burst();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/wb_slave_mem.md
# wb_slave_mem

Wishbone B3 slave memory model answering the Ethernet MAC's DMA master port (m_wb_*), the responder end of the master-side interface. It holds a 2^MEM_AW-word byte-writable array and serves classic and incrementing-burst cycles (CTI/BTE). It also provides programmable wait states and error injection, so the bench can back the MAC's buffer-descriptor and frame DMA with real storage.

## Interface
- ADDR_WIDTH, 32, Wishbone address width
- DATA_WIDTH, 32, data width; byte lanes = DATA_WIDTH/8
- SEL_WIDTH, 4, byte selects
- MEM_AW, 10, word-address bits of the array (depth 1024 words)
- BASE_ADDR, 32'h0000_0000, window base; must be aligned to 2^(MEM_AW+2)

Ports:
- wb_clk_i  in  1  clock
- wb_rst_i  in  1  reset; synchronous, active-high
- wb_adr_i  in  ADDR_WIDTH  byte address from master (m_wb_adr_o)
- wb_dat_i  in  DATA_WIDTH  write data (m_wb_dat_o)
- wb_dat_o  out  DATA_WIDTH  read data (m_wb_dat_i)
- wb_sel_i  in  SEL_WIDTH  byte selects
- wb_we_i  in  1  1 = write, 0 = read
- wb_cyc_i, wb_stb_i  in  1 each  cycle / strobe
- wb_cti_i  in  3  cycle type identifier
- wb_bte_i  in  2  burst type extension
- wb_ack_o  out  1  acknowledge
- wb_err_o  out  1  error
- wait_cfg_i  in  4  wait states inserted before the first beat of each cycle
- err_inj_en_i  in  1  enable error injection
- err_inj_adr_i  in  ADDR_WIDTH  word address whose beat returns err instead of ack
- beat_cnt_o  out  16  count of acked beats, wraps at 2^16

## Operation
- FSM states: IDLE, WAIT, XFER, DONE.
- IDLE: on cyc&stb, latch the address into addr_q and cti/bte, load wait counter = wait_cfg_i, go to WAIT (or XFER if wait_cfg_i=0).
- WAIT: decrement the counter while stb is held; at 0 go to XFER. stb low leaves the counter frozen. cyc low returns to IDLE.
- XFER: one beat per cycle with stb high.
  - Read: wb_dat_o = mem[addr_q[MEM_AW+1:2]].
  - Write: on the ack edge, bytes with sel=1 are updated.
  - Out-of-window address (adr[ADDR_WIDTH-1:MEM_AW+2] ≠ BASE_ADDR field) or an injected match: err instead of ack; no write.
- Beat termination by CTI latched with the beat:
  - 000 classic: single beat, then DONE.
  - 010 incrementing: stay in XFER; next addr from the burst address generator.
  - 111 end-of-burst: last beat, then DONE.
  - 001 constant address: stay in XFER, addr_q unchanged.
  - Other codes are treated as classic.
- Burst address: BTE 00 linear (+4). 01/10/11 wrap within 4/8/16-word aligned blocks; only the low 2/3/4 word bits increment.
- DONE: ack/err low; return to IDLE when stb drops or cyc drops. This enforces at least one idle cycle between classic cycles.
- err terminates the cycle: go to DONE regardless of cti.
- beat_cnt_o increments on every acked beat; err beats are not counted.
- Memory contents are not reset.

## Timing
- Reset values: wb_ack_o=0, wb_err_o=0, wb_dat_o=0, beat_cnt_o=0, state IDLE.
- Latency: ack is registered. With wait_cfg_i=0, the first ack comes in the cycle after cyc&stb is first sampled. Each wait state adds one cycle.
- wb_ack_o/wb_err_o = registered flag AND wb_cyc_i AND wb_stb_i; no ack is given to a deasserted strobe.
- Burst throughput: one beat per cycle after the first while stb is held. Master stb low pauses the burst; addr_q does not advance.
- Read data is registered and valid in the same cycle as ack.
- Simultaneous events:
  - cyc drop on an ack cycle: the beat completes; then IDLE.
  - wait_cfg_i change mid-cycle: takes effect at the next cycle start only.
- Reset mid-operation: all outputs low the next cycle, FSM to IDLE, in-flight beats discarded, memory retained.
- Wrap boundary: in a wrap-4 burst starting at word 0x2, the addresses are 2,3,0,1.

## Structure
- Add to wb_struct_pkg:
  - CTI constants: WB_CTI_CLASSIC=3'b000, WB_CTI_CONST=3'b001, WB_CTI_INCR=3'b010, WB_CTI_EOB=3'b111.
  - BTE constants: WB_BTE_LINEAR, WB_BTE_WRAP4, WB_BTE_WRAP8, WB_BTE_WRAP16.
  - Enum of the FSM states.
- One sub-module, wb_burst_addr_gen: combinational next-word-address from (addr, cti, bte). It is reusable by the planned burst master BFM.

## Test plan
- Classic read, wait 0: preload mem[0x10]=0xA5A5_1234; read adr 0x40 -> ack one cycle after stb, dat=0xA5A5_1234, beat_cnt_o=1.
- Byte write: mem[0x4]=0xFFFF_FFFF; write adr 0x10, sel=4'b0101, dat=0x1122_3344 -> readback 0xFF22_FF44.
- Wait states: wait_cfg_i=3 -> ack on the 4th cycle after stb; stb low during the wait does not advance the count.
- Incrementing wrap-8 read burst from word 0x6 (CTI 010 ×7, then 111) -> 8 consecutive acks, word order 6,7,0..5; then DONE and ack low.
- Error: err_inj_adr_i=0x80 in a linear burst 0x78..0x84 -> acks at 0x78 and 0x7C, err at 0x80, no further ack, memory at 0x80 unchanged. An out-of-window address also errs.
- Reset asserted mid-burst (third beat) -> the next cycle has ack=0, err=0, beat_cnt_o=0, and the written beats persist in memory.
